// File: rtl/maq_contador.sv
// Two-digit BCD modulo-MOD up/down counter with synchronous clear and range-checked load.
// Carry, borrow and load-error are registered one-cycle pulses, so they can drive the next stage's enable.
module maq_contador #(
   parameter int MOD   = 60,
   parameter int MSD_W = 3
) (
   input  logic             maqc_clock,
   input  logic             maqc_reset,
   input  logic             maqc_enable,
   input  logic             maqc_down,
   input  logic             maqc_clear,
   input  logic             maqc_load,
   input  logic [3:0]       maqc_load_lsd,
   input  logic [MSD_W-1:0] maqc_load_msd,
   output logic [3:0]       maqc_lsd,
   output logic [MSD_W-1:0] maqc_msd,
   output logic             maqc_carry,
   output logic             maqc_borrow,
   output logic             maqc_load_err
);

   localparam logic [3:0]       TERM_LSD = 4'((MOD - 1) % 10);
   localparam logic [MSD_W-1:0] TERM_MSD = MSD_W'((MOD - 1) / 10);
   localparam logic [MSD_W-1:0] MSD_ONE  = MSD_W'(1);

   if (MOD < 2 || MOD > 100 || ((MOD - 1) / 10) >= (2 ** MSD_W)) begin : g_bad_param
      $error("maq_contador: illegal MOD/MSD_W combination");
   end

   logic             is_term;
   logic             is_zero;
   logic             out_of_range;
   logic             load_ok;
   logic [3:0]       lsd_nxt;
   logic [MSD_W-1:0] msd_nxt;
   logic             carry_nxt;
   logic             borrow_nxt;
   logic             err_nxt;

   // All range tests are digit-wise, so no binary value of the count is ever formed.
   assign is_term      = (maqc_msd == TERM_MSD) && (maqc_lsd == TERM_LSD);
   assign is_zero      = (maqc_msd == '0) && (maqc_lsd == 4'd0);
   assign out_of_range = (maqc_lsd > 4'd9) || (maqc_msd > TERM_MSD) ||
                         ((maqc_msd == TERM_MSD) && (maqc_lsd > TERM_LSD));
   assign load_ok      = (maqc_load_lsd <= 4'd9) &&
                         ((maqc_load_msd < TERM_MSD) ||
                          ((maqc_load_msd == TERM_MSD) && (maqc_load_lsd <= TERM_LSD)));

   always_comb begin
      // NOTE: every output of this block is defaulted first, so no path leaves one unassigned and no latch is inferred.
      lsd_nxt    = maqc_lsd;
      msd_nxt    = maqc_msd;
      carry_nxt  = 1'b0;
      borrow_nxt = 1'b0;
      err_nxt    = 1'b0;
      if (maqc_clear) begin
         lsd_nxt = 4'd0;
         msd_nxt = '0;
      end else if (maqc_load) begin
         if (load_ok) begin
            lsd_nxt = maqc_load_lsd;
            msd_nxt = maqc_load_msd;
         end else begin
            err_nxt = 1'b1;
         end
      end else if (maqc_enable) begin
         if (!maqc_down) begin
            if (out_of_range) begin
               lsd_nxt = 4'd0;
               msd_nxt = '0;
            end else if (is_term) begin
               lsd_nxt   = 4'd0;
               msd_nxt   = '0;
               carry_nxt = 1'b1;
            end else if (maqc_lsd == 4'd9) begin
               lsd_nxt = 4'd0;
               msd_nxt = maqc_msd + MSD_ONE;
            end else begin
               lsd_nxt = maqc_lsd + 4'd1;
            end
         end else begin
            if (out_of_range) begin
               lsd_nxt = TERM_LSD;
               msd_nxt = TERM_MSD;
            end else if (is_zero) begin
               lsd_nxt    = TERM_LSD;
               msd_nxt    = TERM_MSD;
               borrow_nxt = 1'b1;
            end else if (maqc_lsd == 4'd0) begin
               lsd_nxt = 4'd9;
               msd_nxt = maqc_msd - MSD_ONE;
            end else begin
               lsd_nxt = maqc_lsd - 4'd1;
            end
         end
      end
   end

   always_ff @(posedge maqc_clock or negedge maqc_reset) begin
      if (!maqc_reset) begin
         maqc_lsd      <= 4'd0;
         maqc_msd      <= '0;
         maqc_carry    <= 1'b0;
         maqc_borrow   <= 1'b0;
         maqc_load_err <= 1'b0;
      end else begin
         maqc_lsd      <= lsd_nxt;
         maqc_msd      <= msd_nxt;
         maqc_carry    <= carry_nxt;
         maqc_borrow   <= borrow_nxt;
         maqc_load_err <= err_nxt;
      end
   end

endmodule

// File: tb/tb_maq_contador.sv
// Scoreboard bench for maq_contador: a MOD=60 and a MOD=24 unit checked against an integer model,
// plus a seconds/minutes/hours cascade checked against hand-derived values.
module tb_maq_contador;

   typedef struct {
      int cnt;
      bit c;
      bit b;
      bit e;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   vectors     = 0;
   int   miscompares = 0;

   logic       en_a = 1'b0, dn_a = 1'b0, clr_a = 1'b0, ld_a = 1'b0;
   logic [3:0] ll_a = 4'd0;
   logic [2:0] lm_a = 3'd0;
   logic [3:0] lsd_a;
   logic [2:0] msd_a;
   logic       carry_a, borrow_a, err_a;

   logic       en_h = 1'b0, dn_h = 1'b0, clr_h = 1'b0, ld_h = 1'b0;
   logic [3:0] ll_h = 4'd0;
   logic [1:0] lm_h = 2'd0;
   logic [3:0] lsd_h;
   logic [1:0] msd_h;
   logic       carry_h, borrow_h, err_h;

   logic       tick = 1'b0, ld_c = 1'b0;
   logic [3:0] s_lsd, m_lsd, h_lsd;
   logic [2:0] s_msd, m_msd;
   logic [1:0] h_msd;
   logic       s_carry, m_carry, h_carry, s_borrow, m_borrow, h_borrow, s_err, m_err, h_err;

   int   cnt_a = 0;
   int   cnt_h = 0;
   exp_t q_a[$];
   exp_t q_h[$];

   always #5 clk = ~clk;

   maq_contador #(.MOD(60), .MSD_W(3)) u_m60 (
      .maqc_clock(clk), .maqc_reset(rst_n), .maqc_enable(en_a), .maqc_down(dn_a),
      .maqc_clear(clr_a), .maqc_load(ld_a), .maqc_load_lsd(ll_a), .maqc_load_msd(lm_a),
      .maqc_lsd(lsd_a), .maqc_msd(msd_a), .maqc_carry(carry_a), .maqc_borrow(borrow_a),
      .maqc_load_err(err_a)
   );

   maq_contador #(.MOD(24), .MSD_W(2)) u_m24 (
      .maqc_clock(clk), .maqc_reset(rst_n), .maqc_enable(en_h), .maqc_down(dn_h),
      .maqc_clear(clr_h), .maqc_load(ld_h), .maqc_load_lsd(ll_h), .maqc_load_msd(lm_h),
      .maqc_lsd(lsd_h), .maqc_msd(msd_h), .maqc_carry(carry_h), .maqc_borrow(borrow_h),
      .maqc_load_err(err_h)
   );

   maq_contador #(.MOD(60), .MSD_W(3)) u_sec (
      .maqc_clock(clk), .maqc_reset(rst_n), .maqc_enable(tick), .maqc_down(1'b0),
      .maqc_clear(1'b0), .maqc_load(ld_c), .maqc_load_lsd(4'd9), .maqc_load_msd(3'd5),
      .maqc_lsd(s_lsd), .maqc_msd(s_msd), .maqc_carry(s_carry), .maqc_borrow(s_borrow),
      .maqc_load_err(s_err)
   );

   maq_contador #(.MOD(60), .MSD_W(3)) u_min (
      .maqc_clock(clk), .maqc_reset(rst_n), .maqc_enable(s_carry), .maqc_down(1'b0),
      .maqc_clear(1'b0), .maqc_load(ld_c), .maqc_load_lsd(4'd9), .maqc_load_msd(3'd5),
      .maqc_lsd(m_lsd), .maqc_msd(m_msd), .maqc_carry(m_carry), .maqc_borrow(m_borrow),
      .maqc_load_err(m_err)
   );

   maq_contador #(.MOD(24), .MSD_W(2)) u_hour (
      .maqc_clock(clk), .maqc_reset(rst_n), .maqc_enable(m_carry), .maqc_down(1'b0),
      .maqc_clear(1'b0), .maqc_load(ld_c), .maqc_load_lsd(4'd3), .maqc_load_msd(2'd2),
      .maqc_lsd(h_lsd), .maqc_msd(h_msd), .maqc_carry(h_carry), .maqc_borrow(h_borrow),
      .maqc_load_err(h_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input int exp);
      vectors++;
      if (got !== 32'(exp)) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference behaviour on the integer value of the count.
   task automatic model(input int md, input int cnt, input logic en, input logic dn,
                        input logic clr, input logic ld, input int ll, input int lm,
                        output exp_t ex);
      int nc;
      ex.c = 1'b0;
      ex.b = 1'b0;
      ex.e = 1'b0;
      nc   = cnt;
      if (clr) begin
         nc = 0;
      end else if (ld) begin
         if (ll <= 9 && (10 * lm + ll) <= md - 1) nc = 10 * lm + ll;
         else ex.e = 1'b1;
      end else if (en) begin
         if (!dn) begin
            if (cnt == md - 1) begin nc = 0; ex.c = 1'b1; end
            else nc = cnt + 1;
         end else begin
            if (cnt == 0) begin nc = md - 1; ex.b = 1'b1; end
            else nc = cnt - 1;
         end
      end
      ex.cnt = nc;
   endtask

   task automatic compare(input string tag, input exp_t ex, input logic [31:0] lsd,
                          input logic [31:0] msd, input logic c, input logic b, input logic e);
      check({tag, ".lsd"},    lsd, ex.cnt % 10);
      check({tag, ".msd"},    msd, ex.cnt / 10);
      check({tag, ".carry"},  32'(c), int'(ex.c));
      check({tag, ".borrow"}, 32'(b), int'(ex.b));
      check({tag, ".lderr"},  32'(e), int'(ex.e));
   endtask

   // Push expectations for the edge about to happen, then pop and compare just after it.
   task automatic cycle(input string tag);
      exp_t ex;
      model(60, cnt_a, en_a, dn_a, clr_a, ld_a, int'(ll_a), int'(lm_a), ex);
      cnt_a = ex.cnt;
      q_a.push_back(ex);
      model(24, cnt_h, en_h, dn_h, clr_h, ld_h, int'(ll_h), int'(lm_h), ex);
      cnt_h = ex.cnt;
      q_h.push_back(ex);
      @(posedge clk);
      #1;
      ex = q_a.pop_front();
      compare({tag, "/m60"}, ex, 32'(lsd_a), 32'(msd_a), carry_a, borrow_a, err_a);
      ex = q_h.pop_front();
      compare({tag, "/m24"}, ex, 32'(lsd_h), 32'(msd_h), carry_h, borrow_h, err_h);
   endtask

   task automatic check_zero(input string tag);
      exp_t ex;
      ex.cnt = 0;
      ex.c   = 1'b0;
      ex.b   = 1'b0;
      ex.e   = 1'b0;
      compare({tag, "/m60"}, ex, 32'(lsd_a), 32'(msd_a), carry_a, borrow_a, err_a);
      compare({tag, "/m24"}, ex, 32'(lsd_h), 32'(msd_h), carry_h, borrow_h, err_h);
   endtask

   // Pulls reset low between edges and checks the outputs clear with no clock edge.
   task automatic reset_mid(input string tag);
      #2 rst_n = 1'b0;
      #1;
      cnt_a = 0;
      cnt_h = 0;
      check_zero(tag);
      #2 rst_n = 1'b1;
   endtask

   task automatic idle();
      en_a = 1'b0; dn_a = 1'b0; clr_a = 1'b0; ld_a = 1'b0;
      en_h = 1'b0; dn_h = 1'b0; clr_h = 1'b0; ld_h = 1'b0;
   endtask

   task automatic casc_check(input string tag, input int s, input int m, input int h,
                             input int sc, input int mc, input int hc);
      check({tag, ".s_lsd"}, 32'(s_lsd), s % 10);
      check({tag, ".s_msd"}, 32'(s_msd), s / 10);
      check({tag, ".m_lsd"}, 32'(m_lsd), m % 10);
      check({tag, ".m_msd"}, 32'(m_msd), m / 10);
      check({tag, ".h_lsd"}, 32'(h_lsd), h % 10);
      check({tag, ".h_msd"}, 32'(h_msd), h / 10);
      check({tag, ".s_carry"}, 32'(s_carry), sc);
      check({tag, ".m_carry"}, 32'(m_carry), mc);
      check({tag, ".h_carry"}, 32'(h_carry), hc);
      check({tag, ".side"}, 32'({s_borrow, m_borrow, h_borrow, s_err, m_err, h_err}), 0);
   endtask

   initial begin
      #12;
      check_zero("reset");
      casc_check("reset_casc", 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;

      ld_a = 1'b1; ll_a = 4'd7; lm_a = 3'd5;
      ld_h = 1'b1; ll_h = 4'd2; lm_h = 2'd2;
      cycle("load57_22");

      // Sixty-unit: 58 59 00 01; twenty-four-unit: up 23 00, then down 23 22.
      ld_a = 1'b0; ld_h = 1'b0; en_a = 1'b1; en_h = 1'b1;
      for (int i = 0; i < 4; i++) begin
         dn_h = (i >= 2);
         cycle($sformatf("wrap%0d", i));
      end
      idle();

      ld_a = 1'b1; ll_a = 4'd5; lm_a = 3'd4; cycle("ld45");
      ll_a = 4'd0; lm_a = 3'd6; cycle("ld60_bad");
      ll_a = 4'hA; lm_a = 3'd2; cycle("ld2A_bad");
      ld_a = 1'b0; cycle("hold");

      ld_a = 1'b1; ll_a = 4'd9; lm_a = 3'd5; cycle("ld59");
      en_a = 1'b1; ll_a = 4'd2; lm_a = 3'd1; cycle("ld_over_en");
      clr_a = 1'b1; ll_a = 4'd0; lm_a = 3'd6; cycle("clr_over_ld");
      ld_a = 1'b0; clr_a = 1'b0; dn_a = 1'b1;
      cycle("down_wrap");
      cycle("down_step");
      dn_a = 1'b0; clr_a = 1'b1; cycle("clr_over_en");
      idle();
      cycle("idle");

      ld_c = 1'b1; cycle("casc_ld");
      ld_c = 1'b0;
      casc_check("casc_ld", 59, 59, 23, 0, 0, 0);
      tick = 1'b1; cycle("casc_t0");
      tick = 1'b0;
      casc_check("casc_t0", 0, 59, 23, 1, 0, 0);
      cycle("casc_t1");
      casc_check("casc_t1", 0, 0, 23, 0, 1, 0);
      cycle("casc_t2");
      casc_check("casc_t2", 0, 0, 0, 0, 0, 1);
      cycle("casc_t3");
      casc_check("casc_t3", 0, 0, 0, 0, 0, 0);

      ld_a = 1'b1; ll_a = 4'd7; lm_a = 3'd3;
      ld_h = 1'b1; ll_h = 4'd1; lm_h = 2'd1;
      cycle("ld37");
      idle();
      reset_mid("rst37");

      ld_a = 1'b1; ll_a = 4'd9; lm_a = 3'd5;
      ld_h = 1'b1; ll_h = 4'd3; lm_h = 2'd2;
      cycle("ld59_23");
      idle();
      en_a = 1'b1; en_h = 1'b1;
      cycle("pulse_pending");
      reset_mid("rst_pulse");
      idle();
      cycle("after_rst");

      for (int i = 0; i < 80; i++) begin
         en_a  = ($urandom_range(0, 3) != 0);
         dn_a  = 1'($urandom_range(0, 1));
         clr_a = ($urandom_range(0, 15) == 0);
         ld_a  = ($urandom_range(0, 7) == 0);
         ll_a  = 4'($urandom_range(0, 15));
         lm_a  = 3'($urandom_range(0, 7));
         en_h  = ($urandom_range(0, 3) != 0);
         dn_h  = 1'($urandom_range(0, 1));
         clr_h = ($urandom_range(0, 15) == 0);
         ld_h  = ($urandom_range(0, 7) == 0);
         ll_h  = 4'($urandom_range(0, 15));
         lm_h  = 2'($urandom_range(0, 3));
         cycle($sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
